program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, instruction memory capacity in 32-bit words.
REQ-002 Parameter ADDR_W, default 32, width of imem_addr.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 word_count  input  16  number of words to load; sampled only when start is accepted.
REQ-007 byte_valid  input  1  byte_data holds a valid byte.
REQ-008 byte_data  input  8  program byte stream, little-endian within each word.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 imem_we  output  1  instruction memory write strobe.
REQ-011 imem_addr  output  ADDR_W  word-aligned byte address of the write.
REQ-012 imem_wdata  output  32  assembled instruction word.
REQ-013 cpu_rst  output  1  active-low hold for PC and register file; 0 holds the core in reset.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  single-cycle pulse on load completion.
REQ-016 err  output  1  sticky error: the requested load exceeds DEPTH_WORDS.

Function
REQ-017 The loader SHALL use the states IDLE, RECV, WRITE and DONE.
REQ-018 IDLE: start=1 with 0 < word_count <= DEPTH_WORDS SHALL latch the count, clear err, drive cpu_rst=0, clear word_idx and byte_idx, and enter RECV on the next cycle.
REQ-019 IDLE: start=1 with word_count=0 SHALL drive cpu_rst=0, clear err and enter DONE directly.
REQ-020 IDLE: start=1 with word_count > DEPTH_WORDS SHALL set err=1, remain in IDLE and leave cpu_rst unchanged.
REQ-021 RECV: byte_ready SHALL be 1; byte_ready SHALL be 0 in every other state.
REQ-022 A byte SHALL be accepted only when byte_valid and byte_ready are both 1; byte_idx n places the byte in bits [8n+7:8n].
REQ-023 Acceptance of the byte with byte_idx=3 SHALL move the FSM to WRITE on the next cycle, with byte_idx wrapped to 0.
REQ-024 WRITE: imem_we SHALL be 1 for exactly one cycle, with imem_addr = word_idx*4 and imem_wdata = the assembled word.
REQ-025 WRITE exit: if word_idx = count-1, go to DONE; otherwise increment word_idx and return to RECV.
REQ-026 DONE: assert done=1 for one cycle, set cpu_rst=1, deassert busy and return to IDLE.
REQ-027 busy SHALL be 1 in RECV, WRITE and DONE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 imem_we SHALL be 0 outside WRITE; imem_addr and imem_wdata hold their last values when imem_we=0.
REQ-030 byte_valid=0 in RECV SHALL stall the FSM indefinitely with no timeout and no change of state.
REQ-031 word_idx SHALL be wide enough for DEPTH_WORDS-1; the highest address written SHALL be (DEPTH_WORDS-1)*4.

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE, byte_idx=0, word_idx=0, imem_we=0, imem_addr=0, imem_wdata=0, byte_ready=0, busy=0, done=0, err=0 and cpu_rst=0.
REQ-033 The core SHALL stay held (cpu_rst=0) after reset until the first successful load completes.
REQ-034 rst asserted mid-load SHALL abort the load immediately; partially assembled bytes SHALL be discarded and no write SHALL issue.

Verification
REQ-035 Load 2 words, bytes 13,00,00,00,93,00,10,00 with byte_valid held at 1 -> writes 0x00000013 @0 then 0x00100093 @4, one done pulse, cpu_rst=1 afterwards.
REQ-036 Stream with byte_valid toggled every other cycle, 1 word -> same data written; imem_we asserted exactly once.
REQ-037 start with word_count=0 -> done pulses within 2 cycles, imem_we never 1, cpu_rst=1.
REQ-038 start with word_count=DEPTH_WORDS+1 -> err=1, busy stays 0, no write; a following valid start clears err.
REQ-039 rst pulsed low after 6 of 8 bytes -> only word 0 written, outputs at reset values, cpu_rst=0; a fresh load then succeeds.
REQ-040 start pulsed during RECV -> ignored; word count and addresses unaffected.

Source files
------------

// File: rtl/program_loader_if.sv
// Handshake and memory-write bundle between a byte-stream source/host and the program loader.
// Master drives the load request and byte stream; slave (the loader) drives the rest.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              start;
  logic [15:0]       word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/program_loader.sv
// Loads a little-endian byte stream into instruction memory one 32-bit word at a time,
// holding the CPU in reset until a load completes.
module program_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.slave  bus
);
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic [IDX_W-1:0]  last_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       asm_q;
  logic              byte_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              cpu_rst_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              wc_fits;

  assign wc_fits = 32'(bus.word_count) <= DEPTH_WORDS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      last_q       <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.word_count == '0) begin
              cpu_rst_q <= 1'b0;
              err_q     <= 1'b0;
              busy_q    <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else if (wc_fits) begin
              // Store the final index rather than the count so the WRITE exit test is a plain compare.
              last_q       <= IDX_W'(bus.word_count - 16'd1);
              err_q        <= 1'b0;
              cpu_rst_q    <= 1'b0;
              word_idx_q   <= '0;
              byte_idx_q   <= '0;
              busy_q       <= 1'b1;
              byte_ready_q <= 1'b1;
              state_q      <= RECV;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (bus.byte_valid) begin
            if (byte_idx_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= ADDR_W'({word_idx_q, 2'b00});
              imem_wdata_q <= {bus.byte_data, asm_q};
              byte_idx_q   <= '0;
              byte_ready_q <= 1'b0;
              state_q      <= WRITE;
            end else begin
              if (byte_idx_q == 2'd0)      asm_q[7:0]   <= bus.byte_data;
              else if (byte_idx_q == 2'd1) asm_q[15:8]  <= bus.byte_data;
              else                         asm_q[23:16] <= bus.byte_data;
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        WRITE: begin
          imem_we_q <= 1'b0;
          if (word_idx_q == last_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            word_idx_q   <= word_idx_q + IDX_W'(1);
            byte_ready_q <= 1'b1;
            state_q      <= RECV;
          end
        end
        DONE: begin
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          cpu_rst_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule
